// File: rtl/nibbler_ctrl.sv
// Sequencer for the 4-bit nibbler CPU: fetches one- or two-byte instructions and
// issues the datapath strobes, with free-run, halt and single-step control.
module nibbler_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step_req,
    input  logic [7:0]  program_byte,
    input  logic        c_flag,
    input  logic        z_flag,
    output logic        step_ack,
    output logic        phase,
    output logic [3:0]  instr,
    output logic [3:0]  operand,
    output logic [11:0] address_ram,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        accu_we,
    output logic        flags_we,
    output logic        out_we,
    output logic        ram_we,
    output logic        ram_oe,
    output logic [1:0]  alu_op,
    output logic [1:0]  bus_sel,
    output logic        halted
);

    typedef enum logic [1:0] {StHalt, StFetch, StAddr, StExec} state_e;

    localparam logic [3:0] OpJc   = 4'h0;
    localparam logic [3:0] OpJnc  = 4'h1;
    localparam logic [3:0] OpJz   = 4'h2;
    localparam logic [3:0] OpJnz  = 4'h3;
    localparam logic [3:0] OpJmp  = 4'h4;
    localparam logic [3:0] OpCmpi = 4'h5;
    localparam logic [3:0] OpCmpm = 4'h6;
    localparam logic [3:0] OpLit  = 4'h7;
    localparam logic [3:0] OpOut  = 4'h8;
    localparam logic [3:0] OpAddi = 4'h9;
    localparam logic [3:0] OpAddm = 4'hA;
    localparam logic [3:0] OpNori = 4'hB;
    localparam logic [3:0] OpNorm = 4'hC;
    localparam logic [3:0] OpIn   = 4'hD;
    localparam logic [3:0] OpLd   = 4'hE;
    localparam logic [3:0] OpSt   = 4'hF;

    state_e     state_q, state_d;
    logic [3:0] instr_q, instr_d;
    logic [3:0] operand_q, operand_d;
    logic [7:0] addr_lo_q, addr_lo_d;
    logic       stepping_q, stepping_d;
    logic       step_prev_q, step_prev_d;
    logic       step_ack_q, step_ack_d;

    function automatic logic is_two_byte(input logic [3:0] op);
        case (op)
            OpLit, OpIn, OpOut, OpAddi, OpNori, OpCmpi: is_two_byte = 1'b0;
            default:                                    is_two_byte = 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StHalt;
            instr_q     <= 4'h0;
            operand_q   <= 4'h0;
            addr_lo_q   <= 8'h00;
            stepping_q  <= 1'b0;
            step_prev_q <= 1'b0;
            step_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            operand_q   <= operand_d;
            addr_lo_q   <= addr_lo_d;
            stepping_q  <= stepping_d;
            step_prev_q <= step_prev_d;
            step_ack_q  <= step_ack_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        operand_d   = operand_q;
        addr_lo_d   = addr_lo_q;
        stepping_d  = stepping_q;
        step_prev_d = step_req;
        step_ack_d  = 1'b0;
        case (state_q)
            StHalt: begin
                // Step edges are only looked at here, so earlier ones are dropped.
                if (run) begin
                    state_d = StFetch;
                end else if (step_req && !step_prev_q) begin
                    state_d    = StFetch;
                    stepping_d = 1'b1;
                end
            end
            StFetch: begin
                instr_d   = program_byte[7:4];
                operand_d = program_byte[3:0];
                state_d   = is_two_byte(program_byte[7:4]) ? StAddr : StExec;
            end
            StAddr: begin
                addr_lo_d = program_byte;
                state_d   = StExec;
            end
            StExec: begin
                if (run && !stepping_q) begin
                    state_d = StFetch;
                end else begin
                    state_d    = StHalt;
                    step_ack_d = stepping_q;
                    stepping_d = 1'b0;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    always_comb begin
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        accu_we  = 1'b0;
        flags_we = 1'b0;
        out_we   = 1'b0;
        ram_we   = 1'b0;
        ram_oe   = 1'b0;
        alu_op   = 2'b00;
        bus_sel  = 2'b00;
        case (state_q)
            StFetch, StAddr: pc_inc = 1'b1;
            StExec: begin
                unique case (instr_q)
                    OpJc:   pc_load = c_flag;
                    OpJnc:  pc_load = ~c_flag;
                    OpJz:   pc_load = z_flag;
                    OpJnz:  pc_load = ~z_flag;
                    OpJmp:  pc_load = 1'b1;
                    OpCmpi: begin flags_we = 1'b1; alu_op = 2'b11; end
                    OpCmpm: begin flags_we = 1'b1; alu_op = 2'b11; bus_sel = 2'b01; ram_oe = 1'b1; end
                    OpLit:  accu_we = 1'b1;
                    OpOut:  begin out_we = 1'b1; bus_sel = 2'b11; end
                    OpAddi: begin accu_we = 1'b1; flags_we = 1'b1; alu_op = 2'b01; end
                    OpAddm: begin
                        accu_we = 1'b1; flags_we = 1'b1; alu_op = 2'b01;
                        bus_sel = 2'b01; ram_oe = 1'b1;
                    end
                    OpNori: begin accu_we = 1'b1; flags_we = 1'b1; alu_op = 2'b10; end
                    OpNorm: begin
                        accu_we = 1'b1; flags_we = 1'b1; alu_op = 2'b10;
                        bus_sel = 2'b01; ram_oe = 1'b1;
                    end
                    OpIn:   begin accu_we = 1'b1; bus_sel = 2'b10; end
                    OpLd:   begin accu_we = 1'b1; ram_oe = 1'b1; bus_sel = 2'b01; end
                    OpSt:   begin ram_we = 1'b1; bus_sel = 2'b11; end
                endcase
            end
            default: ;
        endcase
    end

    assign phase       = (state_q == StExec);
    assign halted      = (state_q == StHalt);
    assign step_ack    = step_ack_q;
    assign instr       = instr_q;
    assign operand     = operand_q;
    assign address_ram = {operand_q, addr_lo_q};

endmodule

// File: doc/nibbler_ctrl.md
NIBBLER_CTRL -- requirements
Module: nibbler_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have ports: run  in  1  level; 1 = free-run, 0 = halt at next instruction boundary.
REQ-004 SHALL have ports: step_req  in  1  single-step request; its rising edge is the request event. step_ack  out  1  one-cycle pulse when a stepped instruction completes.
REQ-005 SHALL have ports: program_byte  in  8  ROM data at current PC. c_flag, z_flag  in  1 each  registered flags.
REQ-006 SHALL have ports: phase  out  1  0 in FETCH/ADDR, 1 in EXEC. instr  out  4  opcode register. operand  out  4  operand register. address_ram  out  12  {operand, addr_lo}, also the jump target.
REQ-007 SHALL have ports: pc_inc, pc_load, accu_we, flags_we, out_we, ram_we, ram_oe  out  1 each  strobes. alu_op  out  2  00 pass, 01 add, 10 nor, 11 cmp. bus_sel  out  2  00 operand, 01 RAM, 10 pushbuttons, 11 accu. halted  out  1  state is HALT.

Function
REQ-008 SHALL decode opcodes: 0000 JC, 0001 JNC, 0010 JZ, 0011 JNZ, 0100 JMP, 0101 CMPI, 0110 CMPM, 0111 LIT, 1000 OUT, 1001 ADDI, 1010 ADDM, 1011 NORI, 1100 NORM, 1101 IN, 1110 LD, 1111 ST.
REQ-009 SHALL classify the opcodes into two groups: one-byte = LIT, IN, OUT, ADDI, NORI, CMPI; two-byte = the five jumps, CMPM, ADDM, NORM, LD, ST.
REQ-010 SHALL implement states HALT, FETCH, ADDR, EXEC; sequence: one-byte FETCH->EXEC (2 cycles), two-byte FETCH->ADDR->EXEC (3 cycles).
REQ-011 SHALL, in FETCH, assert pc_inc and load instr<=program_byte[7:4], operand<=program_byte[3:0] at cycle end.
REQ-012 SHALL, in ADDR, assert pc_inc and load addr_lo<=program_byte at cycle end.
REQ-013 SHALL, in EXEC, never assert pc_inc; SHALL assert pc_load only for a taken jump (JMP always; JC c=1; JNC c=0; JZ z=1; JNZ z=0), with flags sampled in that EXEC cycle.
REQ-014 SHALL, in EXEC: LIT accu_we, alu_op 00, bus_sel 00; IN accu_we, alu_op 00, bus_sel 10; OUT out_we, bus_sel 11.
REQ-015 SHALL, in EXEC: ADDI/NORI accu_we+flags_we, alu_op 01/10, bus_sel 00; CMPI flags_we only, alu_op 11, bus_sel 00.
REQ-016 SHALL, in EXEC: ADDM/NORM/CMPM as their immediate forms but with bus_sel 01 and ram_oe; LD accu_we, ram_oe, bus_sel 01, alu_op 00; ST ram_we, bus_sel 11.
REQ-017 SHALL drive all strobes and step_ack to 0 in any state/opcode not listed above; strobes are combinational from state and registers only (no input-to-strobe path except c_flag/z_flag into pc_load).
REQ-018 SHALL, at end of EXEC: go to FETCH if run=1 and not stepping; otherwise go to HALT.
REQ-019 SHALL, in HALT: go to FETCH if run=1; else on step_req rising edge go to FETCH with stepping set. Step events while run=1 or mid-instruction are ignored, never queued.
REQ-020 SHALL, at end of a stepped EXEC: pulse step_ack for the HALT entry cycle, clear stepping, go to HALT; step_req held high yields exactly one instruction.
REQ-021 SHALL complete the current instruction when run falls mid-instruction, never aborting it.

Reset
REQ-022 SHALL, while reset=0, force state HALT, instr=0, operand=0, addr_lo=0, stepping=0, step-edge register=0, all strobes 0, phase 0, step_ack 0, halted 1.
REQ-023 SHALL take effect immediately on reset assertion, including mid-instruction (no pending write strobe survives).
REQ-024 SHALL, on the first rising edge after reset release, go HALT->FETCH if run=1.

Verification
REQ-025 SHALL pass: reset release, run=1, byte 0x79 (LIT 9) -> FETCH pc_inc, then EXEC phase=1, accu_we=1, bus_sel=00, operand=9.
REQ-026 SHALL pass: bytes 0x42,0x34 (JMP) -> FETCH, ADDR pc_inc, EXEC pc_load=1, address_ram=0x234.
REQ-027 SHALL pass: JC with c_flag=0 -> pc_load=0 in EXEC; same with c_flag=1 -> pc_load=1; JNZ with z_flag=0 -> pc_load=1.
REQ-028 SHALL pass: run=0 in HALT, step_req held high 10 cycles on 0x95 (ADDI 5) -> exactly one FETCH/EXEC, accu_we+flags_we once, step_ack one cycle, halted=1 after.
REQ-029 SHALL pass: reset=0 during EXEC of 0xF1,0x00 (ST) -> ram_we drops in the same cycle, halted=1, instr=0.
REQ-030 SHALL pass: run falls during ADDR of CMPM -> EXEC still issues flags_we, ram_oe, alu_op 11, then HALT.
